// File: rtl/buzz_pattern_driver_if.sv
// Buzz-code inputs and buzzer/gate outputs of the buzz pattern driver.
// The master side supplies codes; the slave side (the driver) returns speaker drives.
interface buzz_pattern_driver_if;
    logic [1:0] left_buzz;
    logic [1:0] right_buzz;
    logic       left_spk;
    logic       right_spk;
    logic       left_on;
    logic       right_on;

    modport master (
        output left_buzz, right_buzz,
        input  left_spk, right_spk, left_on, right_on
    );

    modport slave (
        input  left_buzz, right_buzz,
        output left_spk, right_spk, left_on, right_on
    );
endinterface

// File: rtl/buzz_pattern_driver.sv
// Debounces left/right buzz codes and gates a shared square-wave tone per channel:
// continuous for "close", ON/OFF beeping for "both close", silent otherwise.
module buzz_pattern_driver #(
    parameter int TONE_HALF = 4,
    parameter int BEEP_LEN  = 8,
    parameter int DEBOUNCE  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    buzz_pattern_driver_if.slave   bus
);

    localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int PW = (BEEP_LEN  > 1) ? $clog2(BEEP_LEN)  : 1;
    localparam int DW = (DEBOUNCE  > 1) ? $clog2(DEBOUNCE)  : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONT,
        BEEP_ON,
        BEEP_OFF
    } state_t;

    logic [TW-1:0] tone_cnt_q;
    logic          tone_sq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tone_cnt_q <= '0;
            tone_sq_q  <= 1'b0;
        end else if (tone_cnt_q == TW'(TONE_HALF - 1)) begin
            tone_cnt_q <= '0;
            tone_sq_q  <= ~tone_sq_q;
        end else begin
            tone_cnt_q <= tone_cnt_q + TW'(1);
        end
    end

    logic [1:0] buzz_in [2];
    logic [1:0] on_w;
    logic [1:0] spk_w;

    assign buzz_in[0]    = bus.left_buzz;
    assign buzz_in[1]    = bus.right_buzz;
    assign bus.left_on   = on_w[0];
    assign bus.right_on  = on_w[1];
    assign bus.left_spk  = spk_w[0];
    assign bus.right_spk = spk_w[1];

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [1:0]    samp_q;
        logic [1:0]    acc_q;
        logic [1:0]    acc_d;
        logic [DW-1:0] stab_q;
        logic [DW-1:0] stab_d;
        logic [PW-1:0] phase_q;
        state_t        state_q;
        logic          on_q;
        logic          spk_q;
        logic          accept;
        logic          gate;

        always_comb begin
            stab_d = stab_q;
            if (buzz_in[ch] != samp_q) begin
                stab_d = '0;
            end else if (stab_q != DW'(DEBOUNCE - 1)) begin
                stab_d = stab_q + DW'(1);
            end
            accept = (stab_q == DW'(DEBOUNCE - 1)) && (samp_q != acc_q);
            acc_d  = accept ? samp_q : acc_q;
            gate   = (state_q == CONT) || (state_q == BEEP_ON);
        end

        // The gate FSM reacts on the same edge the code is accepted so the
        // registered outputs follow exactly one edge behind the acceptance.
        always_ff @(posedge clk) begin
            if (reset) begin
                samp_q  <= '0;
                stab_q  <= '0;
                acc_q   <= '0;
                phase_q <= '0;
                state_q <= IDLE;
                on_q    <= 1'b0;
                spk_q   <= 1'b0;
            end else begin
                samp_q <= buzz_in[ch];
                stab_q <= stab_d;
                acc_q  <= acc_d;
                on_q   <= gate;
                spk_q  <= gate & tone_sq_q;
                if (accept) begin
                    phase_q <= '0;
                    case (samp_q)
                        2'b10:   state_q <= CONT;
                        2'b01:   state_q <= BEEP_ON;
                        default: state_q <= IDLE;
                    endcase
                end else begin
                    case (state_q)
                        BEEP_ON, BEEP_OFF: begin
                            if (phase_q == PW'(BEEP_LEN - 1)) begin
                                phase_q <= '0;
                                state_q <= (state_q == BEEP_ON) ? BEEP_OFF : BEEP_ON;
                            end else begin
                                phase_q <= phase_q + PW'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign on_w[ch]  = on_q;
        assign spk_w[ch] = spk_q;
    end

endmodule

// File: tb/tb_buzz_pattern_driver.sv
// Self-checking bench for buzz_pattern_driver: directed scenarios plus random code
// sequences, compared each cycle against a window/time-based reference model.
module tb_buzz_pattern_driver;

    localparam int TH  = 4;
    localparam int BL  = 8;
    localparam int DEB = 3;

    logic clk;
    logic reset;
    int   tests;
    int   failed;

    buzz_pattern_driver_if bus ();

    buzz_pattern_driver #(
        .TONE_HALF (TH),
        .BEEP_LEN  (BL),
        .DEBOUNCE  (DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: k = edges since reset; a code is accepted when the last
    // DEB samples (reset value 00 counts as the first) agree and differ from the
    // current accepted code. The gate is derived from time since acceptance.
    int         k;
    logic [1:0] acc   [2];
    int         acc_t [2];
    logic [1:0] hist  [2][DEB];
    int         hn    [2];
    logic       exp_on  [2];
    logic       exp_spk [2];

    function automatic logic gate_at(int ch, int m);
        if (acc[ch] == 2'b10) return 1'b1;
        if (acc[ch] == 2'b01) return (((m - acc_t[ch]) / BL) % 2) == 0;
        return 1'b0;
    endfunction

    function automatic logic tone_at(int m);
        return ((m / TH) % 2) == 1;
    endfunction

    task automatic push(int ch, logic [1:0] v);
        if (hn[ch] < DEB) begin
            hist[ch][hn[ch]] = v;
            hn[ch]++;
        end else begin
            for (int i = 0; i < DEB - 1; i++) hist[ch][i] = hist[ch][i + 1];
            hist[ch][DEB - 1] = v;
        end
    endtask

    task automatic model_reset();
        k = 0;
        for (int ch = 0; ch < 2; ch++) begin
            acc[ch]     = 2'b00;
            acc_t[ch]   = 0;
            hn[ch]      = 0;
            exp_on[ch]  = 1'b0;
            exp_spk[ch] = 1'b0;
            push(ch, 2'b00);
        end
    endtask

    task automatic model_edge(logic [1:0] in0, logic [1:0] in1);
        bit same;
        k++;
        for (int ch = 0; ch < 2; ch++) begin
            exp_on[ch]  = gate_at(ch, k - 1);
            exp_spk[ch] = exp_on[ch] & tone_at(k - 1);
        end
        for (int ch = 0; ch < 2; ch++) begin
            if (hn[ch] == DEB) begin
                same = 1'b1;
                for (int i = 1; i < DEB; i++)
                    if (hist[ch][i] != hist[ch][0]) same = 1'b0;
                if (same && hist[ch][0] != acc[ch]) begin
                    acc[ch]   = hist[ch][0];
                    acc_t[ch] = k;
                end
            end
        end
        push(0, in0);
        push(1, in1);
    endtask

    task automatic chk(string tag, logic obs, logic expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, expv, k);
        end
    endtask

    task automatic step(int n);
        logic [1:0] l;
        logic [1:0] r;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            l = bus.left_buzz;
            r = bus.right_buzz;
            if (reset) model_reset();
            else       model_edge(l, r);
            #1;
            chk("left_on",   bus.left_on,   exp_on[0]);
            chk("right_on",  bus.right_on,  exp_on[1]);
            chk("left_spk",  bus.left_spk,  exp_spk[0]);
            chk("right_spk", bus.right_spk, exp_spk[1]);
        end
    endtask

    task automatic drive(logic [1:0] l, logic [1:0] r);
        bus.left_buzz  = l;
        bus.right_buzz = r;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        model_reset();
        reset = 1'b1;
        drive(2'b10, 2'b10);

        // Reset held with "close" on both sides, then latency of DEB+2 edges.
        step(4);
        reset = 1'b0;
        step(4);
        chk("close_latency_early", bus.left_on, 1'b0);
        step(1);
        chk("close_latency_left",  bus.left_on,  1'b1);
        chk("close_latency_right", bus.right_on, 1'b1);
        step(20);

        // Beeping on the left, silent right.
        drive(2'b01, 2'b00);
        step(40);

        // Short glitch rejected, DEB-cycle pulse accepted.
        drive(2'b01, 2'b10);
        step(2);
        drive(2'b01, 2'b00);
        step(12);
        drive(2'b01, 2'b10);
        step(3);
        drive(2'b01, 2'b00);
        step(12);

        // Switch to continuous mid-beep, then back to beeping.
        drive(2'b00, 2'b00);
        step(10);
        drive(2'b01, 2'b00);
        step(16);
        drive(2'b10, 2'b00);
        step(20);
        drive(2'b01, 2'b00);
        step(24);

        // Reserved code behaves as off.
        drive(2'b11, 2'b11);
        step(20);
        drive(2'b10, 2'b11);
        step(12);

        // Single-cycle reset during BEEP_ON.
        drive(2'b01, 2'b01);
        step(10);
        reset = 1'b1;
        step(1);
        chk("reset_pulse_left_on", bus.left_on, 1'b0);
        reset = 1'b0;
        step(30);

        // Random code sequences with varied hold times and occasional resets.
        for (int it = 0; it < 300; it++) begin
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            reset = ($urandom_range(0, 39) == 0);
            step(1);
            reset = 1'b0;
            step($urandom_range(0, 13));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout edge=%0d", k);
        $fatal(1, "bench did not complete");
    end

endmodule
